// File: rtl/display_scan_scheduler.sv
// Four-digit seven-segment scan scheduler: shares one segment decoder between four
// nibbles, adds per-digit PWM brightness, and swaps display contents only at frame ends.
module display_scan_scheduler #(
    parameter int DIVIDE_BY = 17
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] load_data,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [3:0]  digit_mask,
    input  logic [2:0]  brightness,
    output logic [3:0]  anode,
    output logic [1:0]  digit_sel,
    output logic [3:0]  nibble,
    output logic        frame_done
);

    localparam logic [0:0] STATE_BLANK = 1'b0;
    localparam logic [0:0] STATE_RUN   = 1'b1;

    logic [DIVIDE_BY-1:0] prescale_reg;
    logic [2:0]           subslot_reg;
    logic [1:0]           slot_reg;
    logic [0:0]           state_reg;
    logic [15:0]          active_reg;
    logic [15:0]          pending_reg;
    logic                 pending_full_reg;
    logic [3:0]           mask_slot_reg;
    logic [2:0]           bright_slot_reg;
    logic [3:0]           anode_reg;
    logic [1:0]           digit_sel_reg;
    logic [3:0]           nibble_reg;
    logic                 frame_done_reg;

    logic                 tick;
    logic                 slot_end;
    logic                 commit;
    logic                 transfer;
    logic [3:0]           anode_next;
    logic [3:0]           digit_val [4];

    assign tick     = (prescale_reg == {DIVIDE_BY{1'b1}});
    assign slot_end = tick && (subslot_reg == 3'd7);
    assign commit   = slot_end && (slot_reg == 2'd3);
    assign transfer = load_valid && !pending_full_reg;

    // Each anode bit is driven low only for its own slot, and only during the on-time
    // portion of that slot as set by the brightness latched at slot start.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign digit_val[gi]  = active_reg[gi*4 +: 4];
            assign anode_next[gi] = ~((state_reg == STATE_RUN)
                                      && (slot_reg == 2'(gi))
                                      && mask_slot_reg[gi]
                                      && (subslot_reg <= bright_slot_reg));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            prescale_reg     <= '0;
            subslot_reg      <= 3'd0;
            slot_reg         <= 2'd0;
            state_reg        <= STATE_BLANK;
            active_reg       <= 16'h0000;
            pending_reg      <= 16'h0000;
            pending_full_reg <= 1'b0;
            mask_slot_reg    <= digit_mask;
            bright_slot_reg  <= brightness;
            anode_reg        <= 4'b1111;
            digit_sel_reg    <= 2'd0;
            nibble_reg       <= 4'h0;
            frame_done_reg   <= 1'b0;
        end else begin
            prescale_reg <= prescale_reg + 1'b1;
            if (tick) begin
                subslot_reg <= subslot_reg + 3'd1;
                if (subslot_reg == 3'd7) begin
                    slot_reg <= slot_reg + 2'd1;
                end
            end

            // Latch display settings as the next digit slot begins.
            if (slot_end) begin
                mask_slot_reg   <= digit_mask;
                bright_slot_reg <= brightness;
            end

            anode_reg      <= anode_next;
            digit_sel_reg  <= slot_reg;
            nibble_reg     <= digit_val[slot_reg];
            frame_done_reg <= commit;

            if (commit && pending_full_reg) begin
                active_reg <= pending_reg;
                state_reg  <= STATE_RUN;
            end

            // A transfer is only possible with pending empty, so it never collides with
            // a commit that drains pending; data landing at the commit tick waits a frame.
            if (transfer) begin
                pending_reg      <= load_data;
                pending_full_reg <= 1'b1;
            end else if (commit && pending_full_reg) begin
                pending_full_reg <= 1'b0;
            end
        end
    end

    assign load_ready = ~pending_full_reg;
    assign anode      = anode_reg;
    assign digit_sel  = digit_sel_reg;
    assign nibble     = nibble_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler: directed scenarios plus random traffic, all outputs
// compared every cycle against a cycle-count based reference model.
module tb_display_scan_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] load_data = 16'h0000;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  digit_mask = 4'hF;
    logic [2:0]  brightness = 3'd7;
    logic [3:0]  anode;
    logic [1:0]  digit_sel;
    logic [3:0]  nibble;
    logic        frame_done;

    int check_count = 0;
    int pass_count  = 0;

    display_scan_scheduler #(.DIVIDE_BY(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .digit_mask (digit_mask),
        .brightness (brightness),
        .anode      (anode),
        .digit_sel  (digit_sel),
        .nibble     (nibble),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: counter position derived from the number of clock edges since reset
    // (tick every 4 edges, slot every 32, frame every 128).
    int          t = 0;
    bit          m_run = 0;
    bit          m_pfull = 0;
    bit          m_xfer;
    bit          m_commit;
    logic [15:0] m_active = 16'h0000;
    logic [15:0] m_pending = 16'h0000;
    logic [3:0]  m_mask = 4'hF;
    logic [2:0]  m_bright = 3'd7;
    logic [3:0]  exp_anode = 4'hF;
    logic [1:0]  exp_sel = 2'd0;
    logic [3:0]  exp_nib = 4'h0;
    logic        exp_fd = 1'b0;
    int          m_sub;
    int          m_slot;
    bit          started = 0;

    always @(posedge clock) begin
        started = 1;
        if (reset) begin
            t = 0; m_run = 0; m_pfull = 0;
            m_active = 16'h0000; m_pending = 16'h0000;
            m_mask = digit_mask; m_bright = brightness;
            exp_anode = 4'hF; exp_sel = 2'd0; exp_nib = 4'h0; exp_fd = 1'b0;
        end else begin
            m_sub    = (t / 4) % 8;
            m_slot   = (t / 32) % 4;
            m_commit = ((t % 128) == 127);
            exp_sel  = 2'(m_slot);
            exp_nib  = m_active[m_slot*4 +: 4];
            exp_anode = 4'hF;
            if (m_run && m_mask[m_slot] && (m_sub <= int'(m_bright))) exp_anode[m_slot] = 1'b0;
            exp_fd = m_commit;
            if ((t % 32) == 31) begin
                m_mask = digit_mask;
                m_bright = brightness;
            end
            m_xfer = load_valid && !m_pfull;
            if (m_commit && m_pfull) begin
                m_active = m_pending;
                m_pfull = 0;
                m_run = 1;
            end
            if (m_xfer) begin
                m_pending = load_data;
                m_pfull = 1;
            end
            t++;
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check_value("anode", 32'(anode), 32'(exp_anode));
            check_value("digit_sel", 32'(digit_sel), 32'(exp_sel));
            check_value("nibble", 32'(nibble), 32'(exp_nib));
            check_value("frame_done", 32'(frame_done), 32'(exp_fd));
            check_value("load_ready", 32'(load_ready), 32'(!m_pfull));
        end
    end

    task automatic send(input logic [15:0] data);
        load_data = data;
        load_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    task automatic wait_frame_done(input string tag);
        int n = 0;
        while (frame_done !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) check_value(tag, 32'(frame_done), 32'd1);
    endtask

    int fd_count;
    int low_count;
    int bad_count;

    initial begin
        // 1: blank after reset, frame_done every 128 cycles
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        fd_count = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (frame_done) fd_count++;
        end
        check_value("s1_fd_count", 32'(fd_count), 32'd2);

        // 2: load 4321, full brightness
        digit_mask = 4'hF;
        brightness = 3'd7;
        send(16'h4321);
        check_value("s2_ready_low", 32'(load_ready), 32'd0);
        wait_frame_done("s2_fd_timeout");
        check_value("s2_ready_at_fd", 32'(load_ready), 32'd1);
        repeat (140) @(negedge clock);

        // 3: brightness 1 -> 8 low cycles per slot; then sparse mask
        brightness = 3'd1;
        repeat (160) @(negedge clock);
        low_count = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clock);
            if (anode != 4'hF) low_count++;
        end
        check_value("s3_low_full_mask", 32'(low_count), 32'd32);
        digit_mask = 4'b0101;
        repeat (160) @(negedge clock);
        low_count = 0;
        bad_count = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clock);
            if (anode != 4'hF) low_count++;
            if (anode == 4'b1101 || anode == 4'b0111) bad_count++;
        end
        check_value("s3_low_sparse_mask", 32'(low_count), 32'd16);
        check_value("s3_masked_digits", 32'(bad_count), 32'd0);
        digit_mask = 4'hF;
        brightness = 3'd7;

        // 4: second load while pending is full is dropped
        wait_frame_done("s4_sync_timeout");
        @(negedge clock);
        send(16'hAAAA);
        send(16'hBBBB);
        check_value("s4_ready_low", 32'(load_ready), 32'd0);
        wait_frame_done("s4_fd_timeout");
        repeat (40) @(negedge clock);
        check_value("s4_nibble_a", 32'(nibble), 32'hA);

        // 5: transfer on the commit-tick cycle waits a full frame
        begin
            int n = 0;
            while ((t % 128) != 127 && n < 300) begin
                @(negedge clock);
                n++;
            end
        end
        send(16'h5555);
        check_value("s5_fd_same_edge", 32'(frame_done), 32'd1);
        check_value("s5_ready_low", 32'(load_ready), 32'd0);
        repeat (40) @(negedge clock);
        check_value("s5_old_data", 32'(nibble), 32'hA);
        wait_frame_done("s5_fd_timeout");
        repeat (40) @(negedge clock);
        check_value("s5_new_data", 32'(nibble), 32'h5);

        // 6: mid-frame reset
        repeat (50) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_value("s6_anode", 32'(anode), 32'hF);
        check_value("s6_nibble", 32'(nibble), 32'h0);
        check_value("s6_digit_sel", 32'(digit_sel), 32'd0);
        check_value("s6_ready", 32'(load_ready), 32'd1);
        repeat (200) @(negedge clock);
        check_value("s6_blank", 32'(anode), 32'hF);

        // Random traffic, settings changes and an occasional reset
        for (int i = 0; i < 4000; i++) begin
            load_valid = ($urandom_range(0, 15) == 0);
            load_data  = 16'($urandom());
            if ($urandom_range(0, 99) == 0) digit_mask = 4'($urandom());
            if ($urandom_range(0, 99) == 0) brightness = 3'($urandom());
            reset = ($urandom_range(0, 1999) == 0);
            @(negedge clock);
        end
        load_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
